pipeline_exec_ctrl: RTL and testbench
=====================================

Name: pipeline_exec_ctrl

Overview:
Run/step/stop sequencer for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Generates the common stage enable that gates every pipeline register, including the EX stage's i_enable.
- Accepts commands from the debug unit and counts executed cycles.
- Freezes the pipeline when a HALT instruction reaches WB.
- Sits between the debug/UART front end and the pipeline top.

Parameters:
N_CYCLE_BITS, 32, width of the executed-cycle counter
N_CMD_BITS, 2, width of the command code

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  synchronous, active-high reset
i_cmd_valid  input  1  command present this cycle
i_cmd  input  N_CMD_BITS  command code: 0 NOP, 1 RUN, 2 STEP, 3 STOP
o_cmd_ready  output  1  controller can accept a command this cycle
i_halt_wb  input  1  HALT instruction is in WB this cycle; meaningful only while o_enable=1
o_enable  output  1  pipeline stage enable
o_pipe_clear  output  1  one-cycle pulse telling pipeline registers/PC to reinitialise
o_done  output  1  one-cycle pulse: program finished
o_state  output  2  current state: 0 IDLE, 1 RUN, 2 STEP, 3 DONE
o_cycle_count  output  N_CYCLE_BITS  number of cycles with o_enable=1

Behaviour:
Handshake and timing
- Command is accepted when i_cmd_valid & o_cmd_ready.
- A command accepted at edge k takes effect at edge k; its effect is visible in the cycle after k.
- o_cmd_ready = 1 in IDLE, RUN and DONE; 0 in STEP.
- NOP is accepted and ignored in every state.

Enable and counter
- o_enable is a decode of state: 1 in RUN and STEP, 0 otherwise.
- o_cycle_count increments by 1 at every edge where o_enable=1.
- The counter saturates at all-ones and never wraps.

Reset
- i_reset=1 at an edge, in any state including mid-RUN: state IDLE, o_cycle_count 0, o_done 0, o_pipe_clear 0.
- Resulting outputs: o_enable 0, o_cmd_ready 1, o_state 0.

State transitions, evaluated at each edge in priority order:
- IDLE:
  - RUN -> RUN.
  - STEP -> STEP.
  - STOP -> IDLE (no effect).
- RUN:
  - i_halt_wb=1 -> DONE, with o_done=1 for the next cycle. HALT wins over a simultaneous STOP.
  - Otherwise STOP -> IDLE, a pause; o_cycle_count is held.
  - RUN or STEP -> stay in RUN.
- STEP:
  - Lasts exactly one cycle with o_enable=1, so exactly one instruction advance.
  - Next state is DONE if i_halt_wb=1 in that cycle (o_done pulses), else IDLE.
  - Commands are not accepted here (o_cmd_ready=0).
- DONE:
  - RUN and STEP are accepted but ignored; state stays DONE and o_enable stays 0.
  - STOP -> IDLE, o_pipe_clear=1 for exactly the next cycle, o_cycle_count cleared to 0 at the same edge.

Other rules
- o_done and o_pipe_clear are registered, never both high, and high for exactly one cycle each.
- i_halt_wb is ignored whenever o_enable=0.
- Back-to-back STEP commands: the second one can only be accepted once back in IDLE, so the minimum STEP period is 2 cycles.

Decomposition:
- Shared package pipeline_ctrl_pkg:
  - command codes CMD_NOP/RUN/STEP/STOP;
  - state encodings ST_IDLE/RUN/STEP/DONE;
  - N_CMD_BITS.
  The debug unit and bench import it.
- One sub-module: sat_counter (parameter N_BITS; ports i_clk, i_reset, i_clear, i_inc, o_count), a saturating up-counter with synchronous clear.
- FSM and pulse logic stay in pipeline_exec_ctrl.

Test Plan:
1. Reset mid-run:
   - Stimulus: RUN for 5 cycles, then i_reset=1 for one edge.
   - Required: o_state=0, o_enable=0, o_cycle_count=0, o_cmd_ready=1 in the next cycle.
2. Three steps:
   - Stimulus: from IDLE, STEP issued three times, each once o_cmd_ready=1.
   - Required: o_enable high exactly 3 single cycles; o_cycle_count=3; o_state returns to 0 after each step; o_cmd_ready=0 during each step cycle.
3. Run to halt:
   - Stimulus: RUN, then i_halt_wb=1 in the 10th enabled cycle.
   - Required: o_cycle_count=10; state 3; o_done high exactly one cycle; o_enable=0 afterwards.
4. Simultaneous halt and STOP:
   - Stimulus: in RUN, i_halt_wb=1 in the same cycle as an accepted STOP.
   - Required: state DONE (not IDLE), o_done pulses.
5. DONE handling:
   - Stimulus: in DONE, issue RUN, then STEP, then STOP.
   - Required: RUN and STEP give no enable and state stays 3; STOP gives o_pipe_clear pulse of exactly one cycle, o_cycle_count=0, o_state=0.
6. Saturation:
   - Stimulus: N_CYCLE_BITS=4, RUN for 20 cycles.
   - Required: o_cycle_count stops at 15 and does not wrap; then STOP gives state 0 with count held at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared codes for the pipeline run/step/stop sequencer.
// Imported by the controller, the debug unit and the bench.
package pipeline_ctrl_pkg;

  localparam int N_CMD_BITS = 2;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_STEP = 2'd2,
    CMD_STOP = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int N_BITS = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_inc,
  output logic [N_BITS-1:0] o_count
);

  logic [N_BITS-1:0] cnt_q;
  logic [N_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)
      cnt_d = '0;
    else if (i_inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign o_count = cnt_q;

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Run/step/stop sequencer for the five-stage pipeline.
// Drives the common stage enable and counts enabled cycles.
module pipeline_exec_ctrl #(
  parameter int N_CYCLE_BITS = 32,
  parameter int N_CMD_BITS   = pipeline_ctrl_pkg::N_CMD_BITS
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_cmd_valid,
  input  logic [N_CMD_BITS-1:0]   i_cmd,
  output logic                    o_cmd_ready,
  input  logic                    i_halt_wb,
  output logic                    o_enable,
  output logic                    o_pipe_clear,
  output logic                    o_done,
  output logic [1:0]              o_state,
  output logic [N_CYCLE_BITS-1:0] o_cycle_count
);

  import pipeline_ctrl_pkg::*;

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   clear_q, clear_d;
  logic   cnt_clear;
  logic   accept;
  logic   halt;
  cmd_e   cmd;

  assign cmd      = cmd_e'(i_cmd[1:0]);
  assign o_enable = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign o_cmd_ready = (state_q != ST_STEP);
  assign accept   = i_cmd_valid && o_cmd_ready;
  // halt is only trusted while the pipeline is actually advancing
  assign halt     = i_halt_wb && o_enable;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    clear_d   = 1'b0;
    cnt_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && cmd == CMD_RUN)
          state_d = ST_RUN;
        else if (accept && cmd == CMD_STEP)
          state_d = ST_STEP;
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (accept && cmd == CMD_STOP) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (accept && cmd == CMD_STOP) begin
          state_d   = ST_IDLE;
          clear_d   = 1'b1;
          cnt_clear = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      clear_q <= clear_d;
    end
  end

  sat_counter #(
    .N_BITS (N_CYCLE_BITS)
  ) u_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (cnt_clear),
    .i_inc   (o_enable),
    .o_count (o_cycle_count)
  );

  assign o_done       = done_q;
  assign o_pipe_clear = clear_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Bench for pipeline_exec_ctrl: directed scenarios plus random
// stimulus against a behavioural model of the sequencer.
module tb_pipeline_exec_ctrl;

  import pipeline_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        halt;

  logic        ready, en, clr, done;
  logic [1:0]  st;
  logic [31:0] cnt;
  logic        ready4, en4, clr4, done4;
  logic [1:0]  st4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  int          m_state;
  longint      m_cnt;
  int          m_cnt4;
  bit          m_done;
  bit          m_clr;

  always #5 clk = ~clk;

  pipeline_exec_ctrl #(.N_CYCLE_BITS(32)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_cmd_valid   (cmd_valid),
    .i_cmd         (cmd),
    .o_cmd_ready   (ready),
    .i_halt_wb     (halt),
    .o_enable      (en),
    .o_pipe_clear  (clr),
    .o_done        (done),
    .o_state       (st),
    .o_cycle_count (cnt)
  );

  pipeline_exec_ctrl #(.N_CYCLE_BITS(4)) dut4 (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_cmd_valid   (cmd_valid),
    .i_cmd         (cmd),
    .o_cmd_ready   (ready4),
    .i_halt_wb     (halt),
    .o_enable      (en4),
    .o_pipe_clear  (clr4),
    .o_done        (done4),
    .o_state       (st4),
    .o_cycle_count (cnt4)
  );

  // Behavioural model: advance one clock edge using the inputs
  // present before the edge, then settle 1 time unit past it.
  task automatic tick();
    bit en_m;
    int c;
    @(posedge clk);
    en_m = (m_state == 1) || (m_state == 2);
    c = (cmd_valid && m_state != 2) ? int'(cmd) : 0;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_cnt4 = 0;
      m_done = 0; m_clr = 0;
    end else begin
      m_done = 0;
      m_clr = 0;
      if (en_m) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      case (m_state)
        0: if (c == 1) m_state = 1;
           else if (c == 2) m_state = 2;
        1: if (halt) begin m_state = 3; m_done = 1; end
           else if (c == 3) m_state = 0;
        2: begin m_done = halt; m_state = halt ? 3 : 0; end
        default: if (c == 3) begin
          m_state = 0; m_clr = 1; m_cnt = 0; m_cnt4 = 0;
        end
      endcase
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] c,
                       input bit h);
    cmd_valid = v;
    cmd = c;
    halt = h;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, CMD_NOP, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (st !== 2'd0 || en !== 1'b0 || cnt !== 32'd0 ||
        ready !== 1'b1 || done !== 1'b0 || clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: st=%0d en=%0b cnt=%0d rdy=%0b dn=%0b clr=%0b want 0 0 0 1 0 0",
               st, en, cnt, ready, done, clr);
    end
    drive(1, CMD_RUN, 0);
    tick();
    drive(0, CMD_NOP, 0);
    repeat (5) tick();
    checks++;
    if (st !== 2'd1 || cnt !== 32'd5) begin
      errors++;
      $display("FAIL reset_prerun: st=%0d cnt=%0d want 1 5", st, cnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (st !== 2'd0 || en !== 1'b0 || cnt !== 32'd0 ||
        ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midrun: st=%0d en=%0b cnt=%0d rdy=%0b want 0 0 0 1",
               st, en, cnt, ready);
    end
  endtask

  task automatic test_steps();
    int en_cycles;
    do_reset();
    en_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, CMD_STEP, 0);
      tick();
      drive(0, CMD_NOP, 0);
      en_cycles += int'(en);
      checks++;
      if (st !== 2'd2 || en !== 1'b1 || ready !== 1'b0) begin
        errors++;
        $display("FAIL step_cycle%0d: st=%0d en=%0b rdy=%0b want 2 1 0",
                 i, st, en, ready);
      end
      tick();
      en_cycles += int'(en);
      checks++;
      if (st !== 2'd0 || en !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL step_back%0d: st=%0d en=%0b rdy=%0b want 0 0 1",
                 i, st, en, ready);
      end
    end
    tick();
    en_cycles += int'(en);
    checks++;
    if (cnt !== 32'd3 || en_cycles != 3) begin
      errors++;
      $display("FAIL step_count: cnt=%0d en_cycles=%0d want 3 3",
               cnt, en_cycles);
    end
  endtask

  task automatic test_run_halt();
    do_reset();
    drive(1, CMD_RUN, 0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(0, CMD_NOP, i == 10);
      tick();
    end
    drive(0, CMD_NOP, 0);
    checks++;
    if (cnt !== 32'd10 || st !== 2'd3 || done !== 1'b1 ||
        en !== 1'b0) begin
      errors++;
      $display("FAIL run_halt: cnt=%0d st=%0d dn=%0b en=%0b want 10 3 1 0",
               cnt, st, done, en);
    end
    tick();
    checks++;
    if (done !== 1'b0 || en !== 1'b0 || st !== 2'd3) begin
      errors++;
      $display("FAIL run_halt_after: dn=%0b en=%0b st=%0d want 0 0 3",
               done, en, st);
    end
  endtask

  task automatic test_halt_stop();
    do_reset();
    drive(1, CMD_RUN, 0);
    tick();
    drive(0, CMD_NOP, 0);
    repeat (3) tick();
    drive(1, CMD_STOP, 1);
    tick();
    drive(0, CMD_NOP, 0);
    checks++;
    if (st !== 2'd3 || done !== 1'b1 || cnt !== 32'd4) begin
      errors++;
      $display("FAIL halt_vs_stop: st=%0d dn=%0b cnt=%0d want 3 1 4",
               st, done, cnt);
    end
  endtask

  task automatic test_done();
    drive(1, CMD_RUN, 0);
    tick();
    checks++;
    if (st !== 2'd3 || en !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL done_run: st=%0d en=%0b rdy=%0b want 3 0 1",
               st, en, ready);
    end
    drive(1, CMD_STEP, 0);
    tick();
    checks++;
    if (st !== 2'd3 || en !== 1'b0 || cnt !== 32'd4) begin
      errors++;
      $display("FAIL done_step: st=%0d en=%0b cnt=%0d want 3 0 4",
               st, en, cnt);
    end
    drive(1, CMD_STOP, 0);
    tick();
    drive(0, CMD_NOP, 0);
    checks++;
    if (clr !== 1'b1 || cnt !== 32'd0 || st !== 2'd0 ||
        done !== 1'b0) begin
      errors++;
      $display("FAIL done_stop: clr=%0b cnt=%0d st=%0d dn=%0b want 1 0 0 0",
               clr, cnt, st, done);
    end
    tick();
    checks++;
    if (clr !== 1'b0 || st !== 2'd0) begin
      errors++;
      $display("FAIL done_clr_pulse: clr=%0b st=%0d want 0 0", clr, st);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, CMD_RUN, 0);
    tick();
    drive(0, CMD_NOP, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (int'(cnt4) != ((i < 15) ? i : 15)) begin
        errors++;
        $display("FAIL sat_cycle%0d: cnt4=%0d want %0d",
                 i, cnt4, (i < 15) ? i : 15);
      end
    end
    drive(1, CMD_STOP, 0);
    tick();
    drive(0, CMD_NOP, 0);
    tick();
    checks++;
    if (st4 !== 2'd0 || cnt4 !== 4'd15 || cnt !== 32'd21) begin
      errors++;
      $display("FAIL sat_stop: st=%0d cnt4=%0d cnt=%0d want 0 15 21",
               st4, cnt4, cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (int'(st) != m_state ||
          en !== (m_state == 1 || m_state == 2) ||
          ready !== (m_state != 2) ||
          done !== m_done || clr !== m_clr ||
          longint'(cnt) != m_cnt || int'(cnt4) != m_cnt4) begin
        errors++;
        $display("FAIL random%0d: st=%0d dn=%0b clr=%0b cnt=%0d cnt4=%0d want st=%0d dn=%0b clr=%0b cnt=%0d cnt4=%0d",
                 i, st, done, clr, cnt, cnt4,
                 m_state, m_done, m_clr, m_cnt, m_cnt4);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, CMD_NOP, 0);
    m_state = 0; m_cnt = 0; m_cnt4 = 0;
    m_done = 0; m_clr = 0;
    test_reset();
    test_steps();
    test_run_halt();
    test_halt_stop();
    test_done();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
